// File: rtl/ysyx_24120009_ifu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24120009_ifu_if
//  Description : Bundle of the fetch unit's bus-facing signals: the imem
//                request channel, the imem response channel, the decode-side
//                valid/ready output, and the redirect input.
//  Modports    : master - the fetch unit (drives requests and decode output)
//                slave  - the environment (memory, decode, branch resolution)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_24120009_ifu_if #(
    parameter int DATA_WIDTH = 32
);
    // Instruction memory request channel.
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    // Instruction memory response channel, always accepted.
    logic                  imem_resp_valid;
    logic [DATA_WIDTH-1:0] imem_resp_data;
    logic                  imem_resp_err;
    // Output to decode.
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_inst;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  out_err;
    // Branch/jump redirect.
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output out_valid, out_inst, out_pc, out_err,
        input  out_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  out_valid, out_inst, out_pc, out_err,
        output out_ready,
        output redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24120009_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24120009_ifu
//  Description : Instruction fetch unit. Holds the PC, fetches one
//                instruction at a time from imem, and hands {inst, pc, err}
//                to decode. Redirects flush stale fetches; a watchdog bounds
//                the wait for a memory response.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - ysyx_24120009_ifu_if.master (imem req/resp, decode
//                        output, redirect)
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24120009_ifu #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INST       = 32'h0000_0013,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter int                    CNT_WIDTH      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ysyx_24120009_ifu_if.master   bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  c_wdog_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_pc_step   = DATA_WIDTH'(4);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_drop;      // one outstanding response must be discarded
    logic [CNT_WIDTH-1:0]  r_wdog;
    logic [DATA_WIDTH-1:0] r_out_inst;
    logic [DATA_WIDTH-1:0] r_out_pc;
    logic                  r_out_err;

    logic w_misaligned;
    logic w_wdog_expired;

    assign w_misaligned   = (r_pc[1:0] != 2'b00);
    assign w_wdog_expired = (r_wdog == c_wdog_last);

    // rst_n gates the decoded valids so nothing is offered while reset is held.
    assign bus.imem_req_valid = rst_n && (r_state == S_REQ) && !bus.redirect_valid && !w_misaligned;
    assign bus.imem_req_addr  = r_pc;
    assign bus.out_valid      = rst_n && (r_state == S_OUT);
    assign bus.out_inst       = r_out_inst;
    assign bus.out_pc         = r_out_pc;
    assign bus.out_err        = r_out_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_wdog     <= '0;
            r_out_inst <= NOP_INST;
            r_out_pc   <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // A late response for an abandoned fetch retires the drop.
                    if (bus.imem_resp_valid) begin
                        r_drop <= 1'b0;
                    end
                    if (bus.redirect_valid) begin
                        r_pc <= bus.redirect_pc;
                    end else if (w_misaligned) begin
                        r_out_inst <= NOP_INST;
                        r_out_pc   <= r_pc;
                        r_out_err  <= 1'b1;
                        r_state    <= S_OUT;
                    end else if (bus.imem_req_ready) begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + CNT_WIDTH'(1);
                    if (bus.imem_resp_valid) begin
                        if (r_drop || bus.redirect_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                            if (bus.redirect_valid) begin
                                r_pc <= bus.redirect_pc;
                            end
                        end else begin
                            r_out_inst <= bus.imem_resp_data;
                            r_out_pc   <= r_pc;
                            r_out_err  <= bus.imem_resp_err;
                            r_state    <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        r_pc   <= bus.redirect_pc;
                        r_drop <= 1'b1;
                        // Give up waiting if the watchdog runs out this same cycle;
                        // the pending response stays marked for discard.
                        if (w_wdog_expired) begin
                            r_state <= S_REQ;
                        end
                    end else if (w_wdog_expired) begin
                        if (!r_drop) begin
                            r_out_inst <= NOP_INST;
                            r_out_pc   <= r_pc;
                            r_out_err  <= 1'b1;
                            r_drop     <= 1'b1;
                            r_state    <= S_OUT;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.imem_resp_valid) begin
                        r_drop <= 1'b0;
                    end
                    if (bus.redirect_valid) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= S_REQ;
                    end else if (bus.out_ready) begin
                        r_pc    <= r_pc + c_pc_step;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24120009_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24120009_ifu
//  Description : Self-checking bench for ysyx_24120009_ifu. A one-cycle
//                memory model answers requests; expected decode outputs are
//                queued as stimulus is applied and compared as they appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24120009_ifu;

    localparam logic [31:0] c_nop      = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    ysyx_24120009_ifu_if #(.DATA_WIDTH(32)) bus ();

    ysyx_24120009_ifu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Memory model controls.
    bit          mem_silent = 0;
    bit          mem_err    = 0;
    bit          inject     = 0;
    int          hs_cnt     = 0;
    logic [31:0] last_addr  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0050_0093;
        return a ^ 32'h5A5A_0013;
    endfunction

    // One-cycle memory: a handshake seen in a cycle produces a response
    // pulse in the following cycle. 'inject' forces a stray response.
    initial begin : g_mem
        logic        hs;
        logic [31:0] a;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            a  = bus.imem_req_addr;
            hs = (bus.imem_req_valid && bus.imem_req_ready && !mem_silent) || inject;
            inject = 0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                hs_cnt++;
                last_addr = a;
            end
            @(posedge clk);
            #1;
            bus.imem_resp_valid = hs;
            bus.imem_resp_data  = hs ? mem_word(a) : 32'h0;
            bus.imem_resp_err   = hs && mem_err;
        end
    end

    initial begin : g_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic wait_out(input int budget, output int cyc, output bit to);
        to = 1;
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                cyc = i;
                to  = 0;
                return;
            end
        end
    endtask

    task automatic wait_hs(input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
                to = 0;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        bus.imem_req_ready = 1'b1;
        mem_silent         = 0;
        mem_err            = 0;
        inject             = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req_valid, bus.out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valids: got req/out=%b required 00", {bus.imem_req_valid, bus.out_valid});
        end
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (obs !== exp_t'{c_nop, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", obs, exp_t'{c_nop, 32'h0, 1'b0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== c_reset_pc) begin
            n_fail++;
            $display("FAIL reset_first_req: got valid=%b addr=%h required 1 %h",
                     bus.imem_req_valid, bus.imem_req_addr, c_reset_pc);
        end
        sb_q.push_back('{32'h0050_0093, c_reset_pc, 1'b0});
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL reset_fetch: got %h (timeout=%0d) required %h", obs, to, e);
        end
        n_cmp++;
        if (cyc !== 2) begin
            n_fail++;
            $display("FAIL reset_latency: got %0d cycles after handshake required 2", cyc);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        exp_t held;
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{mem_word(c_reset_pc + 32'(4 * i)), c_reset_pc + 32'(4 * i), 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            wait_out(20, cyc, to);
            e   = sb_q.pop_front();
            obs = '{bus.out_inst, bus.out_pc, bus.out_err};
            n_cmp++;
            if (to || obs !== e) begin
                n_fail++;
                $display("FAIL stream_%0d: got %h (timeout=%0d) required %h", i, obs, to, e);
            end
            n_cmp++;
            if (cyc !== 3) begin
                n_fail++;
                $display("FAIL stream_rate_%0d: got %0d cycles required 3", i, cyc);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        wait_out(20, cyc, to);
        e    = sb_q.pop_front();
        held = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || held !== e) begin
            n_fail++;
            $display("FAIL stream_5th: got %h (timeout=%0d) required %h", held, to, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = '{bus.out_inst, bus.out_pc, bus.out_err};
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 || obs !== e) begin
                n_fail++;
                $display("FAIL stream_hold_%0d: got valid=%b req=%b out=%h required 1 0 %h",
                         i, bus.out_valid, bus.imem_req_valid, obs, e);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        apply_reset();
        bus.out_ready = 1'b1;
        sb_q.push_back('{32'h0050_0093, c_reset_pc, 1'b0});
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL rdw_first: got %h (timeout=%0d) required %h", obs, to, e);
        end
        mem_silent = 1;
        wait_hs(10, to);
        n_cmp++;
        if (to || bus.imem_req_addr !== 32'h8000_0004) begin
            n_fail++;
            $display("FAIL rdw_req_addr: got %h (timeout=%0d) required 80000004", bus.imem_req_addr, to);
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        inject     = 1;
        mem_silent = 0;
        sb_q.push_back('{mem_word(32'h8000_0100), 32'h8000_0100, 1'b0});
        wait_hs(10, to);
        n_cmp++;
        if (to || bus.imem_req_addr !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL rdw_target_addr: got %h (timeout=%0d) required 80000100", bus.imem_req_addr, to);
        end
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL rdw_target_out: got %h (timeout=%0d) required %h", obs, to, e);
        end
    endtask

    task automatic test_redirect_out();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        apply_reset();
        sb_q.push_back('{32'h0050_0093, c_reset_pc, 1'b0});
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL rdo_first: got %h (timeout=%0d) required %h", obs, to, e);
        end
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        @(posedge clk);
        #1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        sb_q.push_back('{mem_word(32'h8000_0200), 32'h8000_0200, 1'b0});
        wait_hs(10, to);
        n_cmp++;
        if (to || bus.imem_req_addr !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL rdo_req_addr: got %h (timeout=%0d) required 80000200", bus.imem_req_addr, to);
        end
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL rdo_target_out: got %h (timeout=%0d) required %h", obs, to, e);
        end
    endtask

    task automatic test_misaligned();
        int   cyc;
        bit   to;
        int   hs0;
        exp_t e;
        exp_t obs;
        apply_reset();
        hs0 = hs_cnt;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_redirect_blocks_req: got req_valid=%b required 0", bus.imem_req_valid);
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req_valid !== 1'b0 || hs_cnt !== hs0) begin
            n_fail++;
            $display("FAIL mis_no_req: got req_valid=%b handshakes=%0d required 0 %0d",
                     bus.imem_req_valid, hs_cnt, hs0);
        end
        sb_q.push_back('{c_nop, 32'h8000_0102, 1'b1});
        wait_out(5, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL mis_out: got %h (timeout=%0d) required %h", obs, to, e);
        end
    endtask

    task automatic test_bus_err();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        apply_reset();
        mem_err = 1;
        sb_q.push_back('{32'h0050_0093, c_reset_pc, 1'b1});
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL bus_err_out: got %h (timeout=%0d) required %h", obs, to, e);
        end
        mem_err = 0;
    endtask

    task automatic test_timeout();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        apply_reset();
        mem_silent = 1;
        sb_q.push_back('{c_nop, c_reset_pc, 1'b1});
        wait_out(400, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e) begin
            n_fail++;
            $display("FAIL timeout_out: got %h (timeout=%0d) required %h", obs, to, e);
        end
        // Handshake, 255 cycles of waiting, then the output cycle.
        n_cmp++;
        if (cyc !== 257) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles required 257", cyc);
        end
        bus.out_ready      = 1'b1;
        bus.imem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        inject        = 1;
        repeat (2) @(posedge clk);
        #1;
        mem_silent         = 0;
        bus.imem_req_ready = 1'b1;
        sb_q.push_back('{mem_word(32'h8000_0004), 32'h8000_0004, 1'b0});
        wait_out(20, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e || cyc !== 3) begin
            n_fail++;
            $display("FAIL timeout_after_late: got %h cyc=%0d (timeout=%0d) required %h cyc=3",
                     obs, cyc, to, e);
        end
    endtask

    task automatic test_mid_reset();
        int   cyc;
        bit   to;
        exp_t e;
        exp_t obs;
        apply_reset();
        mem_silent = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n              = 1'b0;
        inject             = 1;
        bus.imem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.imem_req_addr !== c_reset_pc) begin
                n_fail++;
                $display("FAIL midrst_%0d: got out_valid=%b addr=%h required 0 %h",
                         i, bus.out_valid, bus.imem_req_addr, c_reset_pc);
            end
        end
        @(posedge clk);
        #1;
        mem_silent         = 0;
        bus.imem_req_ready = 1'b1;
        sb_q.push_back('{32'h0050_0093, c_reset_pc, 1'b0});
        wait_out(10, cyc, to);
        e   = sb_q.pop_front();
        obs = '{bus.out_inst, bus.out_pc, bus.out_err};
        n_cmp++;
        if (to || obs !== e || cyc !== 3) begin
            n_fail++;
            $display("FAIL midrst_refetch: got %h cyc=%0d (timeout=%0d) required %h cyc=3",
                     obs, cyc, to, e);
        end
    endtask

    initial begin : g_main
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        test_reset();
        test_stream();
        test_redirect_wait();
        test_redirect_out();
        test_misaligned();
        test_bus_err();
        test_timeout();
        test_mid_reset();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24120009_ifu.md
Name: ysyx_24120009_ifu

Overview:
Instruction fetch unit, directly upstream of the decode stage. Holds the architectural PC and issues fetch requests to instruction memory over a valid/ready request channel plus a response channel. It presents {inst, pc, err} to decode over a valid/ready handshake and accepts PC redirects from branch/jump resolution. Redirects flush stale fetches, and a response watchdog bounds the wait for memory.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction word.
RESET_PC, 32'h8000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction emitted with an error (addi x0,x0,0).
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a fetch error; must be at least 1.
CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  DATA_WIDTH  fetch address; equals the current PC
imem_resp_valid  input  1  response valid (single-cycle pulse; always accepted)
imem_resp_data  input  DATA_WIDTH  fetched instruction
imem_resp_err  input  1  bus error on the fetch
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts
out_inst  output  DATA_WIDTH  instruction to decode (inst_i)
out_pc  output  DATA_WIDTH  PC of out_inst (pc_i)
out_err  output  1  fetch fault: misaligned PC, bus error or timeout
redirect_valid  input  1  branch/jump taken
redirect_pc  input  DATA_WIDTH  redirect target

Behaviour:
- Clock and reset: one clock (clk). rst_n is synchronous and active-low and is sampled only at the rising edge of clk.
- Reset (rst_n=0 at an edge) puts the block in this state, which takes priority over all other inputs and aborts any in-flight operation:
  - state=REQ, pc=RESET_PC, drop=0, wdog=0
  - out_inst=NOP_INST, out_pc=0, out_err=0
  - imem_req_valid=0 and out_valid=0 while rst_n=0
  - a response arriving after reset is released lands in REQ and is ignored.
- State REQ:
  - imem_req_valid = !redirect_valid && pc[1:0]==0. imem_req_addr=pc.
  - redirect_valid: pc<=redirect_pc, stay REQ.
  - pc[1:0]!=0: no request; load out_inst=NOP_INST, out_pc=pc, out_err=1; go OUT.
  - Handshake (imem_req_valid && imem_req_ready): wdog<=0, go WAIT.
- State WAIT: imem_req_valid=0, and wdog increments each cycle.
  - Response with drop=1, or response coinciding with redirect_valid: discard it, drop<=0, go REQ. pc was already updated, or is updated this cycle to redirect_pc.
  - Response with drop=0 and no redirect: out_inst<=imem_resp_data, out_pc<=pc, out_err<=imem_resp_err; go OUT.
  - redirect_valid without a response: pc<=redirect_pc, drop<=1, stay WAIT.
  - Watchdog expiry (wdog==TIMEOUT_CYCLES-1 with no response):
    - with drop=0: out_inst<=NOP_INST, out_pc<=pc, out_err<=1, drop<=1 (a late response must be discarded), go OUT.
    - with drop=1: go REQ.
- State OUT: out_valid=1; out_inst, out_pc and out_err are held stable until the transfer completes.
  - out_ready && !redirect_valid: pc<=pc+4 (modulo 2^DATA_WIDTH, so 0xFFFF_FFFC wraps to 0), go REQ.
  - redirect_valid, regardless of out_ready: pc<=redirect_pc, go REQ. If out_ready was also high, the transfer counts as completed; otherwise the held instruction is discarded.
  - Neither: hold.
- Latency: at best, request handshake cycle N, response N+1, out_valid N+2. Back-to-back throughput is one instruction every 3 cycles; that is the decided rate.
- Late drop: while drop=1, a response arriving in REQ or OUT clears drop and is discarded. At most one outstanding request exists.
- Outputs are registered except imem_req_valid, imem_req_addr and out_valid, which decode from state/pc. imem_req_valid's combinational dependency on redirect_valid is the sole input-to-output path.

Test Plan:
- Reset/fetch: release rst_n with ready=1 and a 1-cycle memory returning 0x00500093 -> req_addr=0x80000000; out_valid 2 cycles after the handshake with out_inst=0x00500093, out_pc=0x80000000, out_err=0.
- Sequential stream with out_ready=1 for 4 instructions -> out_pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C; one per 3 cycles. Then hold out_ready=0 for 5 cycles -> outputs stable and no new request.
- Redirect during WAIT: request pc=0x80000004, redirect 0x80000100 before the response -> the response is discarded, the next request addr is 0x80000100, and the first out_pc is 0x80000100.
- Redirect coinciding with OUT and out_ready=1 -> transfer completes, and the next req_addr is the redirect target, not pc+4.
- Faults:
  - redirect_pc=0x80000102 -> no request; out_err=1, out_inst=0x00000013, out_pc=0x80000102.
  - imem_resp_err=1 -> out_err=1 with the returned data.
  - memory silent for 255 cycles -> out_err=1, NOP_INST; a late response is then discarded.
- Mid-operation reset: assert rst_n=0 in WAIT, then deliver the response in the cycle after release -> out_valid stays 0, and req_addr=0x80000000.
